// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with count-decoded status flags and sticky error flags.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module param_fifo #(
    parameter int FBITS    = 8,
    parameter int PWIDTH   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              clr_fifo,
    input  logic              wr_fifo,
    input  logic              rd_fifo,
    input  logic [FBITS-1:0]  data_in,
    output logic [FBITS-1:0]  data_out,
    output logic              data_out_valid,
    output logic [PWIDTH:0]   data_counter,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow
);

    localparam int FDEPTH = 2 ** PWIDTH;

    localparam logic [PWIDTH:0] C_DEPTH = (PWIDTH + 1)'(FDEPTH);
    localparam logic [PWIDTH:0] C_AF    = (PWIDTH + 1)'(AF_LEVEL);
    localparam logic [PWIDTH:0] C_AE    = (PWIDTH + 1)'(AE_LEVEL);
    localparam logic [PWIDTH:0] C_ONE   = (PWIDTH + 1)'(1);
    localparam logic [PWIDTH-1:0] C_PINC = PWIDTH'(1);

    logic [FBITS-1:0]  r_mem [0:FDEPTH-1];
    logic [PWIDTH-1:0] r_wr_ptr;
    logic [PWIDTH-1:0] r_rd_ptr;
    logic [PWIDTH:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_empty;
    logic w_full;
    logic w_wr_acc;
    logic w_rd_acc;

    // Status comes from the occupancy count only, so full and empty never alias.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH);

    assign w_wr_acc = wr_fifo && !w_full && !clr_fifo;
    assign w_rd_acc = rd_fifo && !w_empty && !clr_fifo;

    assign data_counter = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= C_AE);
    assign almost_full  = (r_count >= C_AF);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage is deliberately left out of the clear.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_fifo) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + C_PINC;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + C_PINC;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
            if (wr_fifo && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_fifo && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef PARAM_FIFO_FWFT_EN

    // Head word is presented combinationally; forced to zero while empty.
    assign data_out       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign data_out_valid = !w_empty;

`else

    logic [FBITS-1:0] r_data_out;
    logic             r_data_valid;

    always_ff @(posedge clk) begin
        if (clr_fifo) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_valid;

`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo in its default registered-read build.
// Each check is an immediate assertion with hand-computed expected values.
module tb_param_fifo;

    logic       clk;
    logic       clr_fifo;
    logic       wr_fifo;
    logic       rd_fifo;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [3:0] data_counter;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic       overflow;
    logic       underflow;

    int n_err;
    int n_checks;

    param_fifo #(
        .FBITS    (8),
        .PWIDTH   (3),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .clk            (clk),
        .clr_fifo       (clr_fifo),
        .wr_fifo        (wr_fifo),
        .rd_fifo        (rd_fifo),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_counter   (data_counter),
        .empty          (empty),
        .full           (full),
        .almost_empty   (almost_empty),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, sample 1 ns later.
    task automatic step(input logic clr, input logic wr, input logic rd,
                        input logic [7:0] din);
        clr_fifo = clr;
        wr_fifo  = wr;
        rd_fifo  = rd;
        data_in  = din;
        @(posedge clk);
        #1;
        clr_fifo = 1'b0;
        wr_fifo  = 1'b0;
        rd_fifo  = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_cnt"}, 32'(data_counter), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_aempty"}, 32'(almost_empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_afull"}, 32'(almost_full), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_udf"}, 32'(underflow), 32'd0);
        chk({tag, "_dout"}, 32'(data_out), 32'h00);
        chk({tag, "_dov"}, 32'(data_out_valid), 32'd0);
    endtask

    initial begin
        n_err    = 0;
        n_checks = 0;
        clr_fifo = 1'b0;
        wr_fifo  = 1'b0;
        rd_fifo  = 1'b0;
        data_in  = 8'h00;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk_cleared("rst");

        // Fill 0x01..0x08 and watch thresholds
        step(1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b1, 1'b0, 8'h02);
        chk("ae_at2", 32'(almost_empty), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h03);
        chk("ae_at3", 32'(almost_empty), 32'd0);
        chk("cnt3", 32'(data_counter), 32'd3);
        step(1'b0, 1'b1, 1'b0, 8'h04);
        step(1'b0, 1'b1, 1'b0, 8'h05);
        chk("af_at5", 32'(almost_full), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h06);
        chk("af_at6", 32'(almost_full), 32'd1);
        chk("cnt6", 32'(data_counter), 32'd6);
        step(1'b0, 1'b1, 1'b0, 8'h07);
        chk("full_at7", 32'(full), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h08);
        chk("full_at8", 32'(full), 32'd1);
        chk("ovf_pre", 32'(overflow), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h09);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("cnt_ovf", 32'(data_counter), 32'd8);
        chk("full_ovf", 32'(full), 32'd1);

        // Drain: 0x01..0x08 in order, 0x09 never appears
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain_data", 32'(data_out), 32'(i));
            chk("drain_dov", 32'(data_out_valid), 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("idle_dov", 32'(data_out_valid), 32'd0);
        chk("idle_hold", 32'(data_out), 32'h08);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("udf_set", 32'(underflow), 32'd1);
        chk("udf_dov", 32'(data_out_valid), 32'd0);
        chk("udf_hold", 32'(data_out), 32'h08);
        chk("udf_cnt", 32'(data_counter), 32'd0);

        // Simultaneous wr/rd at empty and at full
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk_cleared("clr2");
        step(1'b0, 1'b1, 1'b1, 8'h11);
        chk("sim0_cnt", 32'(data_counter), 32'd1);
        chk("sim0_udf", 32'(underflow), 32'd1);
        chk("sim0_dov", 32'(data_out_valid), 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(8'h12 + i));
        end
        chk("sim8_pre", 32'(data_counter), 32'd8);
        step(1'b0, 1'b1, 1'b1, 8'hEE);
        chk("sim8_cnt", 32'(data_counter), 32'd7);
        chk("sim8_ovf", 32'(overflow), 32'd1);
        chk("sim8_dov", 32'(data_out_valid), 32'd1);
        chk("sim8_data", 32'(data_out), 32'h11);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("sim8_drain", 32'(data_out), 32'(8'h12 + i));
        end
        chk("sim8_empty", 32'(empty), 32'd1);

        // Steady wr+rd at count 4: pointers wrap, order kept
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(8'h24 + i));
            chk("wrap_data", 32'(data_out), 32'(8'h20 + i));
            chk("wrap_cnt", 32'(data_counter), 32'd4);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("wrap_tail", 32'(data_out), 32'(8'h34 + i));
        end
        chk("wrap_ovf", 32'(overflow), 32'd0);
        chk("wrap_udf", 32'(underflow), 32'd0);

        // Clear mid-operation with a concurrent write
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("pre_clr_cnt", 32'(data_counter), 32'd5);
        chk("pre_clr_dout", 32'(data_out), 32'h40);
        step(1'b1, 1'b1, 1'b0, 8'h99);
        chk_cleared("clr_wr");
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("post_clr_dov", 32'(data_out_valid), 32'd0);
        chk("post_clr_cnt", 32'(data_counter), 32'd0);
        chk("post_clr_udf", 32'(underflow), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h55);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("post_clr_data", 32'(data_out), 32'h55);
        chk("post_clr_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter FBITS, 8, data word width in bits, SHALL be >= 1.
REQ-002 Parameter PWIDTH, 3, pointer width, SHALL be >= 1; depth FDEPTH = 2**PWIDTH.
REQ-003 Parameter AF_LEVEL, 6, almost-full threshold, SHALL be in 1..FDEPTH.
REQ-004 Parameter AE_LEVEL, 2, almost-empty threshold, SHALL be in 0..FDEPTH-1.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-006 clr_fifo  input  1  reset: synchronous, active-high; also the functional FIFO clear.
REQ-007 wr_fifo  input  1  write request.
REQ-008 rd_fifo  input  1  read request (read acknowledge in FWFT mode).
REQ-009 data_in  input  FBITS  write data.
REQ-010 data_out  output  FBITS  read data.
REQ-011 data_out_valid  output  1  data_out qualifier.
REQ-012 data_counter  output  PWIDTH+1  stored word count, 0..FDEPTH.
REQ-013 empty, full  output  1 each  data_counter==0 and data_counter==FDEPTH respectively.
REQ-014 almost_empty, almost_full  output  1 each  data_counter<=AE_LEVEL and data_counter>=AF_LEVEL respectively.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write SHALL be accepted iff wr_fifo && !full; data_in is stored at wr_ptr and wr_ptr increments modulo FDEPTH.
REQ-017 Read SHALL be accepted iff rd_fifo && !empty; rd_ptr increments modulo FDEPTH.
REQ-018 Flags SHALL be decoded from data_counter only, never from pointer equality.
REQ-019 data_counter SHALL +1 on write-only accept, -1 on read-only accept, and stay unchanged on simultaneous accept or no accept.
REQ-020 Simultaneous wr/rd on empty: write accepted, read rejected, count 0->1.
REQ-021 Simultaneous wr/rd on full: read accepted, write rejected, count FDEPTH->FDEPTH-1.
REQ-022 Simultaneous wr/rd when 0<count<FDEPTH: both accepted, count unchanged, order preserved.
REQ-023 overflow SHALL set on the edge after wr_fifo is asserted while full, and hold until clr_fifo.
REQ-024 underflow SHALL set on the edge after rd_fifo is asserted while empty, and hold until clr_fifo.
REQ-025 Standard mode: on an accepted read at edge N, data_out SHALL be the head word and data_out_valid=1 after edge N; data_out_valid SHALL be 0 after any edge without an accepted read; data_out SHALL otherwise hold its last value.
REQ-026 Pointer wrap-around SHALL be seamless: FDEPTH+k writes interleaved with reads return data in order.

Reset
REQ-027 With clr_fifo=1 at an edge: wr_ptr, rd_ptr and data_counter SHALL become 0; data_out SHALL become 0; data_out_valid, overflow and underflow SHALL become 0; empty=1, almost_empty=1 and full=0 SHALL follow.
REQ-028 clr_fifo SHALL take priority over simultaneous wr_fifo/rd_fifo; the write SHALL be discarded.
REQ-029 Storage contents SHALL NOT be reset; a mid-operation clr_fifo SHALL discard all stored words.

Configuration
REQ-030 Macro PARAM_FIFO_FWFT_EN defined: first-word-fall-through mode; data_out SHALL equal the head word and data_out_valid SHALL equal !empty; rd_fifo SHALL pop the head; a word written at edge N SHALL be visible from edge N when the FIFO was empty.
REQ-031 Macro undefined: standard registered-read mode per REQ-025.

Verification (FBITS=8, PWIDTH=3, AF_LEVEL=6, AE_LEVEL=2)
REQ-032 Write 0x01..0x08, then a 9th write of 0x09 -> full=1, count=8, overflow=1; reads return 0x01..0x08; 0x09 is never returned.
REQ-033 From empty, write 3 words -> almost_empty=0 after the 3rd write; write 3 more -> almost_full=1 at count=6.
REQ-034 Continuous wr+rd for 20 cycles at count=4 -> count stays 4, in-order data, pointers wrap twice without error.
REQ-035 Simultaneous wr/rd at count=0 -> count=1, underflow=1; at count=8 -> count=7, overflow=1.
REQ-036 Assert clr_fifo with count=5 and wr_fifo=1 -> count=0, empty=1, data_out=0x00, all flags 0; the next read is rejected.
REQ-037 FWFT build: write 0xA5 into empty FIFO -> data_out=0xA5, data_out_valid=1 after the same edge; rd_fifo=1 -> data_out_valid=0.
